spwm_sequencer: RTL and testbench

Time-multiplexed scheduler that lets the three phases of the SPWM modulator share a single sine-table read port instead of one table copy per phase. On every PWM carrier boundary it advances a phase accumulator and reads the table three times: base address, base+120°, base+240°. It then commits all three duty words to the per-phase PWM generators on the same clock edge. It sits between the carrier-period source (PWM counter wrap) and the shared `RAM_DUAL` read port, and replaces the free-running address counter / frequency divider pair.

---
 rtl/spwm_sequencer.sv | 113 +++++++++++
 tb/tb_spwm_sequencer.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/spwm_sequencer.sv
// Three-phase SPWM scheduler: one shared sine-table read port, three reads per carrier period,
// with all three duty words committed on the same edge.
module spwm_sequencer #(
    parameter int ADDRESS_BITS  = 8,
    parameter int MEM_WORD_BITS = 8,
    parameter int ACC_BITS      = 24,
    parameter int PHASE_SHIFT_B = 85,
    parameter int PHASE_SHIFT_C = 170
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     enable,
    input  logic                     carrier_sync,
    input  logic [ACC_BITS-1:0]      freq_word,
    output logic [ADDRESS_BITS-1:0]  mem_addr,
    input  logic [MEM_WORD_BITS-1:0] mem_data,
    output logic [MEM_WORD_BITS-1:0] duty_a,
    output logic [MEM_WORD_BITS-1:0] duty_b,
    output logic [MEM_WORD_BITS-1:0] duty_c,
    output logic                     duty_valid,
    output logic                     busy,
    output logic                     overrun
);

    // state | meaning
    // IDLE  | waiting for carrier_sync
    // RD_A  | phase A address on the table port
    // RD_B  | phase B address out, phase A data returning
    // RD_C  | phase C address out, phase B data returning
    // CAP   | phase C data returning, commit all three duties
    typedef enum logic [2:0] {IDLE, RD_A, RD_B, RD_C, CAP} state_t;

    localparam logic [MEM_WORD_BITS-1:0] MID     = {1'b1, {(MEM_WORD_BITS-1){1'b0}}};
    localparam logic [ADDRESS_BITS-1:0]  SHIFT_B = ADDRESS_BITS'(PHASE_SHIFT_B);
    localparam logic [ADDRESS_BITS-1:0]  SHIFT_C = ADDRESS_BITS'(PHASE_SHIFT_C);

    state_t                     state;
    logic [ACC_BITS-1:0]        acc;
    logic [ACC_BITS-1:0]        acc_sum;
    logic [ADDRESS_BITS-1:0]    base;
    logic [MEM_WORD_BITS-1:0]   shadow_a;
    logic [MEM_WORD_BITS-1:0]   shadow_b;

    assign acc_sum = acc + freq_word;
    assign base    = acc[ACC_BITS-1 -: ADDRESS_BITS];

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            acc        <= '0;
            mem_addr   <= '0;
            shadow_a   <= MID;
            shadow_b   <= MID;
            duty_a     <= MID;
            duty_b     <= MID;
            duty_c     <= MID;
            duty_valid <= 1'b0;
            busy       <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            duty_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (carrier_sync) begin
                        if (enable) begin
                            acc      <= acc_sum;
                            mem_addr <= acc_sum[ACC_BITS-1 -: ADDRESS_BITS];
                            busy     <= 1'b1;
                            state    <= RD_A;
                        end else begin
                            acc        <= '0;
                            duty_a     <= MID;
                            duty_b     <= MID;
                            duty_c     <= MID;
                            duty_valid <= 1'b1;
                        end
                    end
                end
                RD_A: begin
                    mem_addr <= base + SHIFT_B;
                    state    <= RD_B;
                end
                RD_B: begin
                    shadow_a <= mem_data;
                    mem_addr <= base + SHIFT_C;
                    state    <= RD_C;
                end
                RD_C: begin
                    shadow_b <= mem_data;
                    mem_addr <= '0;
                    state    <= CAP;
                end
                CAP: begin
                    duty_a     <= shadow_a;
                    duty_b     <= shadow_b;
                    duty_c     <= mem_data;
                    duty_valid <= 1'b1;
                    busy       <= 1'b0;
                    state      <= IDLE;
                end
                default: begin
                    mem_addr <= '0;
                    busy     <= 1'b0;
                    state    <= IDLE;
                end
            endcase
            // A sync that lands mid-sequence is dropped; only the flag records it.
            if (carrier_sync && state != IDLE)
                overrun <= 1'b1;
        end
    end

endmodule

// File: tb/tb_spwm_sequencer.sv
// Bench for spwm_sequencer: directed scenarios plus random traffic, checked every cycle
// against a per-carrier-period reference model over a behavioural sine table.
module tb_spwm_sequencer;

    logic        clk = 1'b0;
    logic        rst, enable, carrier_sync;
    logic [23:0] freq_word;
    logic [7:0]  mem_addr, mem_data, duty_a, duty_b, duty_c;
    logic        duty_valid, busy, overrun;

    logic [7:0]  tbl [256];

    always #5 clk = ~clk;
    always @(posedge clk) mem_data <= tbl[mem_addr];

    spwm_sequencer dut (
        .clk(clk), .rst(rst), .enable(enable), .carrier_sync(carrier_sync),
        .freq_word(freq_word), .mem_addr(mem_addr), .mem_data(mem_data),
        .duty_a(duty_a), .duty_b(duty_b), .duty_c(duty_c),
        .duty_valid(duty_valid), .busy(busy), .overrun(overrun)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference model: one in-flight sequence with a commit countdown.
    logic [23:0] m_acc;
    int          m_cnt;
    logic [7:0]  m_base;
    logic [7:0]  m_pa, m_pb, m_pc;
    logic [7:0]  m_da, m_db, m_dc;
    logic        m_valid, m_ovr;

    function automatic logic [7:0] exp_addr();
        logic [7:0] a;
        case (m_cnt)
            4:       a = m_base;
            3:       a = m_base + 8'd85;
            2:       a = m_base + 8'd170;
            default: a = 8'd0;
        endcase
        return a;
    endfunction

    task automatic model_edge(input logic r, input logic s, input logic e, input logic [23:0] fw);
        logic [7:0] ab, ac;
        m_valid = 1'b0;
        if (r) begin
            m_acc = '0; m_cnt = 0; m_base = '0;
            m_da = 8'd128; m_db = 8'd128; m_dc = 8'd128;
            m_ovr = 1'b0;
        end else if (m_cnt > 0) begin
            if (s) m_ovr = 1'b1;
            m_cnt--;
            if (m_cnt == 0) begin
                m_da = m_pa; m_db = m_pb; m_dc = m_pc;
                m_valid = 1'b1;
            end
        end else if (s) begin
            if (e) begin
                m_acc  = m_acc + fw;
                m_base = m_acc[23:16];
                ab = m_base + 8'd85;
                ac = m_base + 8'd170;
                m_pa = tbl[m_base]; m_pb = tbl[ab]; m_pc = tbl[ac];
                m_cnt = 4;
            end else begin
                m_acc = '0;
                m_da = 8'd128; m_db = 8'd128; m_dc = 8'd128;
                m_valid = 1'b1;
            end
        end
    endtask

    task automatic step(input logic r, input logic s, input logic e, input logic [23:0] fw);
        rst = r; carrier_sync = s; enable = e; freq_word = fw;
        @(posedge clk);
        #1;
        model_edge(r, s, e, fw);
        chk("mem_addr",   32'(mem_addr),   32'(exp_addr()));
        chk("duty_valid", 32'(duty_valid), 32'(m_valid));
        chk("busy",       32'(busy),       32'(m_cnt > 0));
        chk("overrun",    32'(overrun),    32'(m_ovr));
        chk("duties",     32'({duty_a, duty_b, duty_c}), 32'({m_da, m_db, m_dc}));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b1, 24'h0);
    endtask

    task automatic do_reset();
        step(1'b1, 1'b0, 1'b1, 24'h0);
        step(1'b1, 1'b0, 1'b1, 24'h0);
    endtask

    initial begin
        int vcount;
        for (int i = 0; i < 256; i++) tbl[i] = 8'(i);
        m_acc = '0; m_cnt = 0; m_base = '0; m_ovr = 1'b0; m_valid = 1'b0;
        m_da = 8'd128; m_db = 8'd128; m_dc = 8'd128;
        m_pa = '0; m_pb = '0; m_pc = '0;

        // Reset values
        do_reset();
        chk("rst_duty_a", 32'(duty_a), 32'd128);
        chk("rst_duty_c", 32'(duty_c), 32'd128);
        chk("rst_busy",   32'(busy),   32'd0);
        chk("rst_addr",   32'(mem_addr), 32'd0);

        // Single sequence, freq_word = 0
        step(1'b0, 1'b1, 1'b1, 24'h0);
        chk("seq_addr_a", 32'(mem_addr), 32'd0);
        idle(1);
        chk("seq_addr_b", 32'(mem_addr), 32'd85);
        idle(1);
        chk("seq_addr_c", 32'(mem_addr), 32'd170);
        idle(2);
        chk("seq_commit", 32'({duty_valid, duty_a, duty_b, duty_c}), {8'd0, 1'b1, 8'd0, 8'd85, 8'd170});
        idle(1);
        chk("seq_valid_drop", 32'(duty_valid), 32'd0);

        // One address step per carrier, syncs every 8 clocks, base wraps at 256
        do_reset();
        for (int k = 1; k <= 256; k++) begin
            step(1'b0, 1'b1, 1'b1, 24'h010000);
            idle(7);
            if (k == 200)
                chk("base200", 32'({duty_a, duty_b, duty_c}), {8'd0, 8'd200, 8'd29, 8'd114});
            if (k == 256)
                chk("base_wrap", 32'({duty_a, duty_b, duty_c}), {8'd0, 8'd0, 8'd85, 8'd170});
        end

        // Overrun: second sync 2 clocks after the first, then a sync at E5
        do_reset();
        vcount = 0;
        step(1'b0, 1'b1, 1'b1, 24'h123456);
        idle(1);
        step(1'b0, 1'b1, 1'b1, 24'h7F0000);
        chk("ovr_set", 32'(overrun), 32'd1);
        for (int i = 0; i < 2; i++) begin idle(1); vcount += int'(duty_valid); end
        step(1'b0, 1'b1, 1'b1, 24'h010000);
        chk("ovr_e5_accept", 32'(busy), 32'd1);
        chk("ovr_count", 32'(vcount), 32'd1);
        chk("ovr_first_dut", 32'({duty_a, duty_b, duty_c}), {8'd0, 8'h12, 8'h12 + 8'd85, 8'h12 + 8'd170});
        idle(6);
        chk("ovr_sticky", 32'(overrun), 32'd1);

        // Disable after running, then re-enable
        step(1'b0, 1'b1, 1'b0, 24'h550000);
        chk("dis_commit", 32'({duty_valid, duty_a, duty_b, duty_c}), {8'd0, 1'b1, 8'd128, 8'd128, 8'd128});
        idle(3);
        step(1'b0, 1'b1, 1'b1, 24'h3A0000);
        chk("reenable_base", 32'(mem_addr), 32'h3A);
        idle(6);

        // Reset during RD_C
        step(1'b0, 1'b1, 1'b1, 24'h200000);
        idle(2);
        step(1'b1, 1'b0, 1'b1, 24'h0);
        chk("midrst", 32'({busy, duty_valid, overrun, duty_a}), {21'd0, 1'b0, 1'b0, 1'b0, 8'd128});
        idle(6);

        // Random traffic, table reshuffled between sequences
        for (int i = 0; i < 2000; i++) begin
            if (m_cnt == 0 && $urandom_range(0, 49) == 0)
                for (int j = 0; j < 256; j++) tbl[j] = 8'($urandom);
            step($urandom_range(0, 149) == 0, $urandom_range(0, 3) == 0,
                 $urandom_range(0, 9) != 0, 24'($urandom));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
